// File: rtl/wbm_arb.sv
// Three-requester Wishbone master arbiter with round-robin grant.
// Optional stall timeout enabled by defining WBM_ARB_TIMEOUT_EN.
module wbm_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        r0_cyc_i,
  input  logic        r0_stb_i,
  input  logic        r0_we_i,
  input  logic        r0_cab_i,
  input  logic [3:0]  r0_sel_i,
  input  logic [31:0] r0_adr_i,
  input  logic [31:0] r0_dat_i,
  output logic        r0_ack_o,
  output logic        r0_err_o,
  output logic        r0_rty_o,
  output logic [31:0] r0_dat_o,
  input  logic        r1_cyc_i,
  input  logic        r1_stb_i,
  input  logic        r1_we_i,
  input  logic        r1_cab_i,
  input  logic [3:0]  r1_sel_i,
  input  logic [31:0] r1_adr_i,
  input  logic [31:0] r1_dat_i,
  output logic        r1_ack_o,
  output logic        r1_err_o,
  output logic        r1_rty_o,
  output logic [31:0] r1_dat_o,
  input  logic        r2_cyc_i,
  input  logic        r2_stb_i,
  input  logic        r2_we_i,
  input  logic        r2_cab_i,
  input  logic [3:0]  r2_sel_i,
  input  logic [31:0] r2_adr_i,
  input  logic [31:0] r2_dat_i,
  output logic        r2_ack_o,
  output logic        r2_err_o,
  output logic        r2_rty_o,
  output logic [31:0] r2_dat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic        wbm_cab_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i,
  output logic        arb_busy_o,
  output logic [1:0]  arb_grant_o
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state;
  logic [1:0]  owner;
  logic [1:0]  nxt;
  logic [2:0]  cyc_v;
  logic        own;
  logic        tout;

  logic        o_cyc;
  logic        o_stb;
  logic        o_we;
  logic        o_cab;
  logic [3:0]  o_sel;
  logic [31:0] o_adr;
  logic [31:0] o_dat;

  assign cyc_v = {r2_cyc_i, r1_cyc_i, r0_cyc_i};
  assign own   = (state == OWN);

  // Round-robin pick: search starts just after the last owner
  always_comb begin
    nxt = 2'd0;
    case (owner)
      2'd0: nxt = cyc_v[1] ? 2'd1 : (cyc_v[2] ? 2'd2 : 2'd0);
      2'd1: nxt = cyc_v[2] ? 2'd2 : (cyc_v[0] ? 2'd0 : 2'd1);
      default: nxt = cyc_v[0] ? 2'd0 : (cyc_v[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Grant FSM; owner doubles as the last-owner pointer through IDLE
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (|cyc_v) begin
            state <= OWN;
            owner <= nxt;
          end
        end
        OWN: begin
          if (!o_cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select the owner's bus signals
  always_comb begin
    o_cyc = r2_cyc_i;
    o_stb = r2_stb_i;
    o_we  = r2_we_i;
    o_cab = r2_cab_i;
    o_sel = r2_sel_i;
    o_adr = r2_adr_i;
    o_dat = r2_dat_i;
    case (owner)
      2'd0: begin
        o_cyc = r0_cyc_i;
        o_stb = r0_stb_i;
        o_we  = r0_we_i;
        o_cab = r0_cab_i;
        o_sel = r0_sel_i;
        o_adr = r0_adr_i;
        o_dat = r0_dat_i;
      end
      2'd1: begin
        o_cyc = r1_cyc_i;
        o_stb = r1_stb_i;
        o_we  = r1_we_i;
        o_cab = r1_cab_i;
        o_sel = r1_sel_i;
        o_adr = r1_adr_i;
        o_dat = r1_dat_i;
      end
      default: ;
    endcase
  end

`ifdef WBM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] tcnt;
  logic          stall;

  // Raw owner strobe is used so the forced-low bus cannot feed back
  assign stall = own & o_stb & ~(wbm_ack_i | wbm_err_i | wbm_rty_i);
  assign tout  = stall && (tcnt == CW'(TIMEOUT - 1));

  // Count consecutive stalled strobe cycles; clear on response or timeout
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tcnt <= '0;
    end else if (!stall || tout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tout = 1'b0;
`endif

  assign wbm_cyc_o = own & o_cyc & ~tout;
  assign wbm_stb_o = own & o_stb & ~tout;
  assign wbm_we_o  = own & o_we;
  assign wbm_cab_o = own & o_cab;
  assign wbm_sel_o = own ? o_sel : 4'd0;
  assign wbm_adr_o = own ? o_adr : 32'd0;
  assign wbm_dat_o = own ? o_dat : 32'd0;

  assign r0_ack_o = own && (owner == 2'd0) && wbm_ack_i;
  assign r1_ack_o = own && (owner == 2'd1) && wbm_ack_i;
  assign r2_ack_o = own && (owner == 2'd2) && wbm_ack_i;
  assign r0_err_o = own && (owner == 2'd0) && (wbm_err_i || tout);
  assign r1_err_o = own && (owner == 2'd1) && (wbm_err_i || tout);
  assign r2_err_o = own && (owner == 2'd2) && (wbm_err_i || tout);
  assign r0_rty_o = own && (owner == 2'd0) && wbm_rty_i;
  assign r1_rty_o = own && (owner == 2'd1) && wbm_rty_i;
  assign r2_rty_o = own && (owner == 2'd2) && wbm_rty_i;

  assign r0_dat_o = wbm_dat_i;
  assign r1_dat_o = wbm_dat_i;
  assign r2_dat_o = wbm_dat_i;

  assign arb_busy_o  = own;
  assign arb_grant_o = owner;

endmodule

// File: tb/tb_wbm_arb.sv
// Directed vector bench for wbm_arb.
// Timeout section follows WBM_ARB_TIMEOUT_EN.
module tb_wbm_arb;

  logic        clk;
  logic        rst;
  logic [2:0]  cyc;
  logic        ack, err, rty;
  logic [31:0] sdat;

  logic        a0, e0, y0, a1, e1, y1, a2, e2, y2;
  logic [31:0] d0, d1, d2;
  logic        m_cyc, m_stb, m_we, m_cab;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat;
  logic        busy;
  logic [1:0]  gnt;

  int checks = 0;
  int failures = 0;

  wbm_arb #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .r0_cyc_i(cyc[0]), .r0_stb_i(cyc[0]), .r0_we_i(1'b0),
    .r0_cab_i(1'b0), .r0_sel_i(4'hF), .r0_adr_i(32'h100),
    .r0_dat_i(32'hA0), .r0_ack_o(a0), .r0_err_o(e0),
    .r0_rty_o(y0), .r0_dat_o(d0),
    .r1_cyc_i(cyc[1]), .r1_stb_i(cyc[1]), .r1_we_i(1'b1),
    .r1_cab_i(1'b1), .r1_sel_i(4'hF), .r1_adr_i(32'h200),
    .r1_dat_i(32'hA1), .r1_ack_o(a1), .r1_err_o(e1),
    .r1_rty_o(y1), .r1_dat_o(d1),
    .r2_cyc_i(cyc[2]), .r2_stb_i(cyc[2]), .r2_we_i(1'b0),
    .r2_cab_i(1'b1), .r2_sel_i(4'h3), .r2_adr_i(32'h300),
    .r2_dat_i(32'hA2), .r2_ack_o(a2), .r2_err_o(e2),
    .r2_rty_o(y2), .r2_dat_o(d2),
    .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_we_o(m_we),
    .wbm_cab_o(m_cab), .wbm_sel_o(m_sel), .wbm_adr_o(m_adr),
    .wbm_dat_o(m_dat), .wbm_ack_i(ack), .wbm_err_i(err),
    .wbm_rty_i(rty), .wbm_dat_i(sdat),
    .arb_busy_o(busy), .arb_grant_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  cyc;
    logic        ack;
    logic [31:0] sdat;
    logic        e_cyc;
    logic        e_stb;
    logic        e_busy;
    logic [1:0]  e_gnt;
    logic [2:0]  e_ack;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
  } vec_t;

  vec_t v[31];

  function automatic vec_t mk(logic r, logic [2:0] c, logic a,
                              logic [31:0] sd, logic ec, logic es,
                              logic eb, logic [1:0] eg,
                              logic [2:0] ea, logic [31:0] ead);
    vec_t t;
    t.rst = r; t.cyc = c; t.ack = a; t.sdat = sd;
    t.e_cyc = ec; t.e_stb = es; t.e_busy = eb; t.e_gnt = eg;
    t.e_ack = ea; t.e_adr = ead; t.e_dat = sd;
    return t;
  endfunction

  initial begin
    // reset, then r0 alone with a two-wait-state read
    v[0]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    v[1]  = mk(1, 3'b001, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    v[2]  = mk(0, 3'b001, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    v[3]  = mk(0, 3'b001, 0, 0, 1, 1, 1, 0, 3'b000, 32'h100);
    v[4]  = mk(0, 3'b001, 0, 0, 1, 1, 1, 0, 3'b000, 32'h100);
    v[5]  = mk(0, 3'b001, 1, 32'h12345678, 1, 1, 1, 0, 3'b001, 32'h100);
    v[6]  = mk(0, 3'b000, 0, 0, 0, 0, 1, 0, 3'b000, 32'h100);
    v[7]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0);
    // simultaneous requests after reset: 0,1,2
    v[8]  = mk(1, 3'b111, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    v[9]  = mk(0, 3'b111, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    v[10] = mk(0, 3'b111, 1, 32'h11, 1, 1, 1, 0, 3'b001, 32'h100);
    v[11] = mk(0, 3'b110, 0, 0, 0, 0, 1, 0, 3'b000, 32'h100);
    v[12] = mk(0, 3'b110, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0);
    v[13] = mk(0, 3'b110, 1, 32'h22, 1, 1, 1, 1, 3'b010, 32'h200);
    v[14] = mk(0, 3'b100, 0, 0, 0, 0, 1, 1, 3'b000, 32'h200);
    v[15] = mk(0, 3'b100, 0, 0, 0, 0, 0, 1, 3'b000, 32'h0);
    v[16] = mk(0, 3'b100, 1, 32'h33, 1, 1, 1, 2, 3'b100, 32'h300);
    v[17] = mk(0, 3'b000, 0, 0, 0, 0, 1, 2, 3'b000, 32'h300);
    v[18] = mk(0, 3'b000, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    // r1 four-beat burst with r0 waiting
    v[19] = mk(0, 3'b010, 0, 0, 0, 0, 0, 2, 3'b000, 32'h0);
    v[20] = mk(0, 3'b011, 1, 32'h41, 1, 1, 1, 1, 3'b010, 32'h200);
    v[21] = mk(0, 3'b011, 1, 32'h42, 1, 1, 1, 1, 3'b010, 32'h200);
    v[22] = mk(0, 3'b011, 0, 0, 1, 1, 1, 1, 3'b000, 32'h200);
    v[23] = mk(0, 3'b011, 1, 32'h43, 1, 1, 1, 1, 3'b010, 32'h200);
    v[24] = mk(0, 3'b011, 1, 32'h44, 1, 1, 1, 1, 3'b010, 32'h200);
    v[25] = mk(0, 3'b001, 0, 0, 0, 0, 1, 1, 3'b000, 32'h200);
    v[26] = mk(0, 3'b001, 0, 0, 0, 0, 0, 1, 3'b000, 32'h0);
    v[27] = mk(0, 3'b001, 0, 0, 1, 1, 1, 0, 3'b000, 32'h100);
    // hand over to r2, then r0 pends during r2's burst
    v[28] = mk(0, 3'b100, 0, 0, 0, 0, 1, 0, 3'b000, 32'h100);
    v[29] = mk(0, 3'b100, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0);
    v[30] = mk(0, 3'b101, 1, 32'h55, 1, 1, 1, 2, 3'b100, 32'h300);

    rst = 1'b1; cyc = 3'b000; ack = 0; err = 0; rty = 0; sdat = 0;

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      rst = v[i].rst; cyc = v[i].cyc; ack = v[i].ack; sdat = v[i].sdat;
      #1;
      chk("cyc", i, {31'd0, m_cyc}, {31'd0, v[i].e_cyc});
      chk("stb", i, {31'd0, m_stb}, {31'd0, v[i].e_stb});
      chk("busy", i, {31'd0, busy}, {31'd0, v[i].e_busy});
      chk("grant", i, {30'd0, gnt}, {30'd0, v[i].e_gnt});
      chk("ack", i, {29'd0, a2, a1, a0}, {29'd0, v[i].e_ack});
      chk("adr", i, m_adr, v[i].e_adr);
      chk("dat0", i, d0, v[i].e_dat);
      chk("dat2", i, d2, v[i].e_dat);
      chk("errs", i, {29'd0, e2, e1, e0}, 32'd0);
    end

    // async reset mid-cycle during r2's burst
    #2 rst = 1'b1;
    #1;
    chk("rst_cyc", 100, {31'd0, m_cyc}, 32'd0);
    chk("rst_busy", 100, {31'd0, busy}, 32'd0);
    chk("rst_ack2", 100, {31'd0, a2}, 32'd0);
    chk("rst_gnt", 100, {30'd0, gnt}, 32'd2);
    @(negedge clk);
    ack = 0;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("post_busy", 101, {31'd0, busy}, 32'd1);
    chk("post_gnt", 101, {30'd0, gnt}, 32'd0);
    chk("post_adr", 101, m_adr, 32'h100);

    // release r0 and let the bus go idle
    @(negedge clk);
    cyc = 3'b000;
    @(negedge clk);
    #1;
    chk("idle_busy", 102, {31'd0, busy}, 32'd0);

    // r1 strobes into a slave that never answers
    @(negedge clk);
    cyc = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      chk("st_busy", 200 + k, {31'd0, busy}, 32'd1);
      chk("st_gnt", 200 + k, {30'd0, gnt}, 32'd1);
`ifdef WBM_ARB_TIMEOUT_EN
      chk("st_err", 200 + k, {31'd0, e1}, {31'd0, k == 4});
      chk("st_cyc", 200 + k, {31'd0, m_cyc}, {31'd0, k != 4});
`else
      chk("st_err", 200 + k, {31'd0, e1}, 32'd0);
      chk("st_cyc", 200 + k, {31'd0, m_cyc}, 32'd1);
`endif
      chk("st_err0", 200 + k, {31'd0, e0 | e2}, 32'd0);
    end

    @(negedge clk);
    cyc = 3'b000;
    @(negedge clk);
    #1;
    chk("end_busy", 300, {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbm_arb.md
WBM_ARB -- requirements
Module: wbm_arb

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255, meaning stalled-strobe cycles before a forced error (used only with WBM_ARB_TIMEOUT_EN).
REQ-002 The module SHALL have input wb_clk_i, 1 bit: the single clock.
REQ-003 The module SHALL have input wb_rst_i, 1 bit: asynchronous, active-high reset.
REQ-004 For requesters n = 0 (descriptor fetch), 1 (channel 0) and 2 (channel 1), the module SHALL have these inputs: rN_cyc_i, rN_stb_i, rN_we_i, rN_cab_i (1 bit each), rN_sel_i [3:0], rN_adr_i [31:0], rN_dat_i [31:0].
REQ-005 For each requester n, the module SHALL have these outputs: rN_ack_o, rN_err_o, rN_rty_o (1 bit each) and rN_dat_o [31:0].
REQ-006 The module SHALL have these shared-bus master outputs: wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o (1 bit each), wbm_sel_o [3:0], wbm_adr_o [31:0], wbm_dat_o [31:0].
REQ-007 The module SHALL have these shared-bus master inputs: wbm_ack_i, wbm_err_i, wbm_rty_i (1 bit each) and wbm_dat_i [31:0].
REQ-008 The module SHALL have status outputs arb_busy_o (1 bit: a grant is held) and arb_grant_o [1:0] (current or last owner index), for register readback.

Function
REQ-009 The module SHALL implement two states: IDLE and OWN.
- IDLE -> OWN on any rN_cyc_i.
- OWN -> IDLE when the owner's cyc_i is low.
REQ-010 The grant SHALL be registered: the bus is driven on the cycle after the request is first sampled (1-cycle arbitration latency).
REQ-011 Arbitration SHALL be round-robin: search starts at last_owner+1 mod 3; index 3 is never granted.
REQ-012 In OWN, the module SHALL route all master outputs combinationally from the owner's inputs, with wbm_cyc_o = owner cyc_i and wbm_stb_o = owner stb_i.
REQ-013 In IDLE, all master outputs SHALL be 0.
REQ-014 wbm_ack_i, wbm_err_i and wbm_rty_i SHALL be routed only to the owner; non-owners SHALL see 0.
REQ-015 rN_dat_o SHALL equal wbm_dat_i for all n.
REQ-016 The grant SHALL be held for the owner's whole cyc_i assertion, including cab bursts and rty responses; no preemption.
REQ-017 After a release there SHALL be exactly one IDLE cycle with wbm_cyc_o = 0 before the next owner is driven, even when other requests are pending.
REQ-018 If several requests become active on the same cycle, the round-robin order SHALL decide the grant.
REQ-019 A requester dropping cyc_i while not owner SHALL have no effect.
REQ-020 arb_busy_o SHALL be 1 exactly in OWN.
REQ-021 arb_grant_o SHALL update on each grant and hold its value through IDLE.

Reset
REQ-022 While wb_rst_i is high, the state SHALL be IDLE; arb_busy_o = 0; arb_grant_o = 2'd2, so r0 wins first; all master outputs and all rN_ack/err/rty_o SHALL be 0; the timeout counter SHALL be 0.
REQ-023 Reset asserted mid-transfer SHALL drop wbm_cyc_o asynchronously, without waiting for a clock.
REQ-024 After reset release, the first grant SHALL be available on the second rising edge.

Configuration
REQ-025 With macro WBM_ARB_TIMEOUT_EN defined, a counter SHALL increment each OWN cycle where wbm_stb_o = 1 and none of ack/err/rty is set, and clear otherwise.
REQ-026 With WBM_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT, the module SHALL:
- pulse the owner's err_o for one cycle;
- force wbm_cyc_o/wbm_stb_o to 0 in that cycle;
- clear the counter;
- keep the grant until the owner drops cyc_i.
REQ-027 Without WBM_ARB_TIMEOUT_EN, there SHALL be no counter and err_o SHALL come only from wbm_err_i.

Verification
REQ-028 Reset, then r0 alone: r0_cyc/stb=1 with single read, slave acks after 2 cycles with dat 0x12345678 -> wbm_cyc_o=1 one cycle after the request; r0_ack_o=1 with r0_dat_o=0x12345678; r1/r2_ack_o=0.
REQ-029 r0, r1 and r2 request together and hold cyc for one access each -> grant order 0,1,2; arb_grant_o goes 0,1,2; one IDLE cycle between owners.
REQ-030 r1 runs a 4-beat cab burst while r0 requests -> r1 keeps the bus for all 4 acks, then r0 is granted after one IDLE cycle.
REQ-031 wb_rst_i is pulsed mid-burst of r2 -> wbm_cyc_o=0 immediately; after release, r0 (pending) is granted first.
REQ-032 With WBM_ARB_TIMEOUT_EN and TIMEOUT=4, r1 strobes and the slave never responds -> r1_err_o=1 for one cycle at the 4th stalled cycle with wbm_cyc_o=0; without the macro, the stall persists with no err.
